// File: rtl/guf_pkg.sv
// guf_pkg: command/mode encodings and FSM state enum for guf_ctrl (VERIFY state exists only with GUF_CTRL_VERIFY_EN)
package guf_pkg;
  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_PROG  = 2'b01;
  localparam logic [1:0] CMD_ERASE = 2'b10;
  localparam logic [1:0] CMD_ILL   = 2'b11;
  localparam logic [3:0] MODE_READ  = 4'b0001;
  localparam logic [3:0] MODE_PROG  = 4'b0010;
  localparam logic [3:0] MODE_ERASE = 4'b0100;
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RECOVER,
`ifdef GUF_CTRL_VERIFY_EN
    VERIFY,
`endif
    DONE
  } state_t;
endpackage

// File: rtl/guf_timer.sv
// guf_timer: 8-bit loadable down-counter that stops at zero
module guf_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld,
  input  logic [7:0] val,
  output logic       zero
);
  logic [7:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (ld) cnt <= val;
    else if (cnt != 8'd0) cnt <= cnt - 8'd1;
  assign zero = cnt == 8'd0;
endmodule

// File: rtl/guf_ctrl.sv
// guf_ctrl: flash macro sequencer (read/program/erase); GUF_CTRL_VERIFY_EN adds program read-back verification
module guf_ctrl
  import guf_pkg::*;
#(
  parameter int READ_WAIT = 2,
  parameter int PROG_CYC  = 8,
  parameter int ERASE_CYC = 16,
  parameter int RECOV     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  cmd,
  input  logic [17:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy,
  output logic [5:0]  f_ra,
  output logic [5:0]  f_ca,
  output logic [5:0]  f_pa,
  output logic [3:0]  f_mode,
  output logic [1:0]  f_seq,
  output logic        f_aclk,
  output logic [1:0]  f_rmode,
  output logic [1:0]  f_wmode,
  output logic [1:0]  f_rbytesel,
  output logic [1:0]  f_wbytesel,
  output logic        f_pw,
  output logic        f_pe,
  output logic        f_oe,
  output logic        f_reset,
  output logic [31:0] f_din,
  input  logic [31:0] f_dout
);
  state_t state, nxt;
  logic [1:0] op;
  logic [17:0] ad;
  logic [31:0] wd;
  logic err_q, ld, zero, vph, setup, rd;
  logic [7:0] acc_len, ld_val;
  assign rd = op == CMD_READ || vph;
  assign acc_len = rd ? 8'(READ_WAIT - 1) : op == CMD_PROG ? 8'(PROG_CYC - 1) : 8'(ERASE_CYC - 1);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req) nxt = cmd == CMD_ILL ? DONE : SETUP;
      SETUP:   nxt = ACCESS;
      ACCESS:  if (zero) nxt = RECOVER;
`ifdef GUF_CTRL_VERIFY_EN
      RECOVER: if (zero) nxt = (op == CMD_PROG && !vph) ? VERIFY : DONE;
      VERIFY:  nxt = ACCESS;
`else
      RECOVER: if (zero) nxt = DONE;
`endif
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign ld = (nxt == ACCESS && state != ACCESS) || (nxt == RECOVER && state != RECOVER);
  assign ld_val = nxt == ACCESS ? acc_len : 8'(RECOV - 1);
  guf_timer u_timer (.clk(clk), .reset(reset), .ld(ld), .val(ld_val), .zero(zero));
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      op <= '0;
      ad <= '0;
      wd <= '0;
      err_q <= 1'b0;
      rdata <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req) begin
        op <= cmd;
        ad <= addr;
        wd <= wdata;
        err_q <= cmd == CMD_ILL;
      end
      if (state == ACCESS && zero && op == CMD_READ) rdata <= f_dout;
`ifdef GUF_CTRL_VERIFY_EN
      if (state == ACCESS && zero && vph) err_q <= f_dout != wd;
`endif
    end
`ifdef GUF_CTRL_VERIFY_EN
  // vph marks the read-back half of a verified program
  always_ff @(posedge clk)
    if (reset) vph <= 1'b0;
    else if (state == IDLE) vph <= 1'b0;
    else if (nxt == VERIFY) vph <= 1'b1;
  assign setup = state == SETUP || state == VERIFY;
`else
  assign vph = 1'b0;
  assign setup = state == SETUP;
`endif
  assign ack = state == DONE;
  assign busy = state != IDLE && state != DONE;
  assign err = ack & err_q;
  assign f_oe = state == ACCESS && rd;
  assign f_pw = state == ACCESS && op == CMD_PROG && !vph;
  assign f_pe = state == ACCESS && op == CMD_ERASE;
  assign f_aclk = setup;
  assign f_seq = setup ? 2'b01 : state == ACCESS ? 2'b10 : 2'b00;
  assign f_mode = !busy ? 4'd0 : rd ? MODE_READ : op == CMD_PROG ? MODE_PROG : MODE_ERASE;
  assign {f_ra, f_ca, f_pa} = ad;
  assign f_din = wd;
  assign f_reset = reset;
  assign f_rmode = 2'b00;
  assign f_wmode = 2'b00;
  assign f_rbytesel = 2'b00;
  assign f_wbytesel = 2'b00;
endmodule

// File: doc/guf_ctrl.md
GUF_CTRL -- requirements
Module: guf_ctrl

Interface
REQ-001 Parameter READ_WAIT, default 2, SHALL set the oe-asserted cycles per read (range 1..15).
REQ-002 Parameter PROG_CYC, default 8, SHALL set the pw-asserted cycles per word program (range 1..255).
REQ-003 Parameter ERASE_CYC, default 16, SHALL set the pe-asserted cycles per page erase (range 1..255).
REQ-004 Parameter RECOV, default 2, SHALL set the idle-strobe cycles after any access (range 1..15).
REQ-005 Ports, in order: clk in 1 system clock; reset in 1 sync active-high reset; req in 1 command strobe; cmd in 2 (00 read, 01 program, 10 erase, 11 illegal); addr in 18 {ra,ca,pa}; wdata in 32 program data; rdata out 32 read result; ack out 1 one-cycle completion pulse; err out 1 error flag, valid with ack; busy out 1 operation in progress.
REQ-006 Flash-side ports: f_ra/f_ca/f_pa out 6 each; f_mode out 4; f_seq out 2; f_aclk out 1; f_rmode/f_wmode/f_rbytesel/f_wbytesel out 2 each, tied 0; f_pw/f_pe/f_oe/f_reset out 1; f_din out 32; f_dout in 32.
REQ-007 Single clock domain: clk; reset is synchronous and active-high.

Function
REQ-008 FSM states SHALL be IDLE, SETUP, ACCESS, RECOVER, DONE (plus VERIFY when enabled).
REQ-009 In IDLE with req=1 and cmd!=11, the block SHALL latch cmd/addr/wdata, set busy=1 on the next edge, and enter SETUP.
REQ-010 In IDLE with req=1 and cmd=11, the block SHALL go to DONE with err=1 and no flash strobe asserted.
REQ-011 req while busy=1 SHALL be ignored, with no queueing.
REQ-012 SETUP lasts 1 cycle: drive f_ra/f_ca/f_pa, f_mode per cmd, f_din=wdata, f_seq=01, f_aclk=1.
REQ-013 ACCESS SHALL assert exactly one of f_oe/f_pw/f_pe for READ_WAIT/PROG_CYC/ERASE_CYC cycles; for read, rdata SHALL capture f_dout on the last ACCESS cycle.
REQ-014 RECOVER SHALL hold all strobes low and f_seq=00 for RECOV cycles while the address stays stable.
REQ-015 DONE lasts 1 cycle with ack=1, then returns to IDLE; busy clears in the same cycle ack rises.
REQ-016 Latency, with req sampled in cycle 0: ack SHALL occur in cycle 2+N+RECOV, where N is the ACCESS length.
REQ-017 The cycle counter SHALL be 8 bits, load N-1 on entry, and count down to 0; it never wraps.
REQ-018 err SHALL be 0 on every successful completion.
REQ-019 rdata SHALL hold its value until the next completed read.

Reset
REQ-020 On reset, the FSM SHALL go to IDLE; all flash strobes, f_aclk, f_seq, ack, err and busy SHALL be 0, rdata=0, and f_reset=1 for that cycle.
REQ-021 Reset mid-operation SHALL drop all strobes on the same edge and SHALL produce no ack.

Configuration
REQ-022 The macro GUF_CTRL_VERIFY_EN SHALL control program read-back verification.
REQ-023 With GUF_CTRL_VERIFY_EN defined, a program SHALL run RECOVER, then a full read (SETUP/ACCESS/RECOVER) of the same address, and err=1 if f_dout!=wdata; ack is delayed by 1+READ_WAIT+RECOV cycles.
REQ-024 Without GUF_CTRL_VERIFY_EN, there SHALL be no VERIFY state or compare logic, and program err is always 0.

Structure
REQ-025 Package guf_pkg SHALL hold the cmd encodings, the f_mode constants (MODE_READ, MODE_PROG, MODE_ERASE), and the FSM state enum.
REQ-026 Sub-module guf_timer, an 8-bit loadable down-counter with a zero flag, SHALL be used for all wait phases.

Verification
REQ-027 Read: with defaults, req cmd=00 addr=0x01234 and model dout=0xDEADBEEF -> f_oe high cycles 2-3, ack cycle 6, rdata=0xDEADBEEF, err=0.
REQ-028 Program: cmd=01 wdata=0xA5A5A5A5 -> f_pw high exactly 8 cycles, f_din stable, ack cycle 12 (verify off).
REQ-029 Erase: cmd=10 -> f_pe high 16 cycles, ack cycle 20; a req during busy is ignored, with no second ack.
REQ-030 Illegal cmd=11 -> ack and err=1 within 2 cycles; f_oe/f_pw/f_pe never asserted.
REQ-031 Reset at cycle 5 of an erase -> f_pe=0 next edge, busy=0, no ack; a following read completes normally.
REQ-032 With VERIFY_EN, model corrupts bit 0 -> program ack at cycle 17 with err=1; with matching data, err=0.
